// File: rtl/pwm_duty_capture.sv
// PWM receive-side capture: measures high time and rising-to-rising period of a
// synchronized PWM input, and flags a line stuck high or low.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for the first rising edge; no measurement in progress
// HIGH  | line high since last rise; acc counts high time
// LOW   | line low after a fall; acc keeps counting towards full period
module pwm_duty_capture #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             meas_valid,
    output logic             stuck_hi,
    output logic             stuck_lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ACC_MAX = '1;
    localparam logic [CNT_W-1:0] ACC_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_prev;
    logic                   s;
    logic                   rise;
    logic                   fall;
    logic                   acc_sat;
    logic [CNT_W-1:0]       acc;
    logic [CNT_W-1:0]       hi_len;
    state_t                 state;

    // The synchronizer and edge register run regardless of ena so that
    // re-enabling never sees a stale edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            s_prev <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            s_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s       = sync_q[SYNC_STAGES-1];
    assign rise    = s & ~s_prev;
    assign fall    = ~s & s_prev;
    assign acc_sat = (acc == ACC_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            hi_len     <= '0;
            high_cnt   <= '0;
            period_cnt <= '0;
            meas_valid <= 1'b0;
            stuck_hi   <= 1'b0;
            stuck_lo   <= 1'b0;
        end else if (!ena) begin
            state      <= IDLE;
            acc        <= '0;
            hi_len     <= '0;
            meas_valid <= 1'b0;
            stuck_hi   <= 1'b0;
            stuck_lo   <= 1'b0;
        end else begin
            meas_valid <= 1'b0;

            if (rise) begin
                acc <= ACC_ONE;
            end else if (!acc_sat) begin
                acc <= acc + ACC_ONE;
            end

            if (rise || fall) begin
                stuck_hi <= 1'b0;
                stuck_lo <= 1'b0;
            end

            // An edge in the saturating cycle takes priority over the stuck exit.
            case (state)
                IDLE: begin
                    if (rise) state <= HIGH;
                end
                HIGH: begin
                    if (fall) begin
                        state  <= LOW;
                        hi_len <= acc;
                    end else if (acc_sat) begin
                        stuck_hi <= 1'b1;
                        state    <= IDLE;
                    end
                end
                LOW: begin
                    if (rise) begin
                        state      <= HIGH;
                        high_cnt   <= hi_len;
                        period_cnt <= acc;
                        meas_valid <= 1'b1;
                    end else if (acc_sat) begin
                        stuck_lo <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Directed bench for pwm_duty_capture (CNT_W=6 so stuck thresholds are reachable);
// every publish is logged and compared against hand-computed values.
module tb_pwm_duty_capture;

    localparam int CNT_W = 6;

    logic             clk;
    logic             rst;
    logic             ena;
    logic             pwm_in;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic             meas_valid;
    logic             stuck_hi;
    logic             stuck_lo;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int b2b = 0;
    logic prev_valid = 1'b0;
    logic [31:0] hq[$];
    logic [31:0] pq[$];
    int          cq[$];

    pwm_duty_capture #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .pwm_in     (pwm_in),
        .high_cnt   (high_cnt),
        .period_cnt (period_cnt),
        .meas_valid (meas_valid),
        .stuck_hi   (stuck_hi),
        .stuck_lo   (stuck_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every publish with the cycle it happened in.
    always @(negedge clk) begin
        cyc++;
        if (meas_valid === 1'b1) begin
            hq.push_back(32'(high_cnt));
            pq.push_back(32'(period_cnt));
            cq.push_back(cyc);
            if (prev_valid) b2b++;
        end
        prev_valid = meas_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pwm_period(input int h, input int l, input int n);
        repeat (n) begin
            pwm_in = 1'b1;
            tick(h);
            pwm_in = 1'b0;
            tick(l);
        end
    endtask

    task automatic clear_log();
        hq.delete();
        pq.delete();
        cq.delete();
    endtask

    function automatic logic [31:0] hv(input int i);
        return (i < hq.size()) ? hq[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] pv(input int i);
        return (i < pq.size()) ? pq[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] gap(input int i);
        return (i < cq.size() && i > 0) ? 32'(cq[i] - cq[i-1]) : 32'hFFFF_FFFF;
    endfunction

    initial begin
        rst = 1'b1;
        ena = 1'b1;
        pwm_in = 1'b0;
        tick(3);
        chk("rst_high_cnt", 32'(high_cnt), 0);
        chk("rst_period_cnt", 32'(period_cnt), 0);
        chk("rst_valid", 32'(meas_valid), 0);
        chk("rst_stuck", {30'd0, stuck_hi, stuck_lo}, 0);
        rst = 1'b0;
        tick(3);

        // 3 high / 5 low, four periods -> three publishes 8 cycles apart
        clear_log();
        pwm_period(3, 5, 4);
        tick(6);
        chk("p35_count", hq.size(), 3);
        chk("p35_high", 32'(high_cnt), 3);
        chk("p35_period", 32'(period_cnt), 8);
        chk("p35_gap1", gap(1), 8);
        chk("p35_gap2", gap(2), 8);

        // duty step 2/10 -> 7/10; leftover period is 3 high + 11 low
        clear_log();
        pwm_period(2, 8, 3);
        pwm_period(7, 3, 3);
        tick(5);
        chk("step_count", hq.size(), 6);
        chk("step_first_h", hv(0), 3);
        chk("step_first_p", pv(0), 14);
        chk("step_pre_h", hv(3), 2);
        chk("step_pre_p", pv(3), 10);
        chk("step_post_h", hv(4), 7);
        chk("step_post_p", pv(4), 10);
        chk("step_last_h", hv(5), 7);

        // stuck high: publishes 7/15, then saturates 63 cycles after the rise
        clear_log();
        pwm_in = 1'b1;
        tick(65);
        chk("sh_before", 32'(stuck_hi), 0);
        tick(1);
        chk("sh_set", 32'(stuck_hi), 1);
        tick(4);
        chk("sh_held", 32'(stuck_hi), 1);
        chk("sh_lo_clear", 32'(stuck_lo), 0);
        chk("sh_count", hq.size(), 1);
        chk("sh_pub_h", hv(0), 7);
        chk("sh_pub_p", pv(0), 15);
        pwm_in = 1'b0;
        tick(4);
        chk("sh_cleared", 32'(stuck_hi), 0);
        chk("sh_no_valid", hq.size(), 1);
        chk("sh_hold_p", 32'(period_cnt), 15);

        // stuck low: rise from IDLE, short high, then line held low
        clear_log();
        pwm_period(3, 70, 1);
        chk("sl_set", 32'(stuck_lo), 1);
        chk("sl_no_valid", hq.size(), 0);
        chk("sl_hold_h", 32'(high_cnt), 7);

        // rise exactly when acc saturates in LOW publishes 63, not stuck
        clear_log();
        pwm_in = 1'b1;
        tick(10);
        chk("sl_cleared", 32'(stuck_lo), 0);
        pwm_in = 1'b0;
        tick(53);
        pwm_period(4, 4, 3);
        chk("sat_count", hq.size(), 3);
        chk("sat_h", hv(0), 10);
        chk("sat_p", pv(0), 63);
        chk("sat_next_p", pv(1), 8);
        chk("sat_no_stuck", {30'd0, stuck_hi, stuck_lo}, 0);

        // enable dropped for 20 cycles, then needs two rises
        pwm_period(4, 4, 2);
        clear_log();
        ena = 1'b0;
        pwm_period(4, 6, 2);
        chk("ena_no_valid", hq.size(), 0);
        chk("ena_hold_h", 32'(high_cnt), 4);
        chk("ena_hold_p", 32'(period_cnt), 8);
        ena = 1'b1;
        pwm_period(3, 3, 3);
        tick(4);
        chk("ena_count", hq.size(), 2);
        chk("ena_h", hv(0), 3);
        chk("ena_p", pv(0), 6);

        // 1 high / 1 low: publish every other cycle
        clear_log();
        pwm_period(1, 1, 6);
        tick(4);
        chk("fast_count", hq.size(), 6);
        chk("fast_first_p", pv(0), 10);
        chk("fast_h", hv(5), 1);
        chk("fast_p", pv(5), 2);
        chk("fast_gap", gap(5), 2);
        chk("no_back_to_back", b2b, 0);

        // async reset mid high phase
        pwm_in = 1'b1;
        tick(2);
        rst = 1'b1;
        pwm_in = 1'b0;
        #1;
        chk("mid_rst_h", 32'(high_cnt), 0);
        chk("mid_rst_p", 32'(period_cnt), 0);
        chk("mid_rst_valid", 32'(meas_valid), 0);
        tick(2);
        rst = 1'b0;
        tick(3);
        clear_log();
        pwm_period(3, 5, 3);
        tick(4);
        chk("post_rst_count", hq.size(), 2);
        chk("post_rst_h", hv(0), 3);
        chk("post_rst_p", pv(1), 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
